// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, port id, pipeline stage structs and arbiter pointer enum
package dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_MEM_AW = 7;

  typedef logic port_id_t;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_ptr_e;

  // we/re are stored already masked by err, so they can drive the memory directly
  typedef struct packed {
    logic                   vld;
    port_id_t               port;
    logic                   we;
    logic                   re;
    logic [DMEM_MEM_AW-1:0] idx;
    logic [DMEM_DATA_W-1:0] wdata;
    logic                   err;
  } s1_t;

  typedef struct packed {
    logic     vld;
    port_id_t port;
    logic     err;
    logic     had_re;
  } s2_t;

endpackage

// File: rtl/dmem_rr_arb2.sv
// rtl/dmem_rr_arb2.sv - 2-way grant; round-robin when DMEM_ARB_RR_EN is defined, else port 0 fixed priority
module dmem_rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

`ifdef DMEM_ARB_RR_EN
  arb_ptr_e r_ptr;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) o_grant = (r_ptr == PRI0) ? 2'b01 : 2'b10;
  end

  // The pointer only moves on contention, so a lone requester never spends the other port's turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PRI0;
    end else if (i_valid == 2'b11) begin
      r_ptr <= (r_ptr == PRI0) ? PRI1 : PRI0;
    end
  end
`else
  logic w_unused;
  assign w_unused = clk ^ rst_n;

  always_comb begin
    o_grant = i_valid;
    if (i_valid[0]) o_grant = 2'b01;
  end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester arbiter and command/response pipeline for the 128x32 data memory (DMEM_ARB_RR_EN selects round-robin)
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int MEM_AW = DMEM_MEM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_re,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        w_grant;
  logic              w_fire;
  port_id_t          w_port;
  logic [ADDR_W-1:0] w_addr;
  logic              w_err;
  s1_t               r_s1;
  s2_t               r_s2;

  dmem_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (req_valid),
    .o_grant (w_grant)
  );

  assign req_ready = rst_n ? w_grant : 2'b00;
  assign w_fire    = |req_ready;
  assign w_port    = req_ready[1];
  assign w_addr    = w_port ? req_addr1 : req_addr0;
  assign w_err     = (w_addr[1:0] != 2'b00) || (w_addr[ADDR_W-1:MEM_AW+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else if (w_fire) begin
      r_s1.vld   <= 1'b1;
      r_s1.port  <= w_port;
      r_s1.we    <= req_we[w_port] & ~w_err;
      r_s1.re    <= req_re[w_port] & ~w_err;
      r_s1.idx   <= w_addr[MEM_AW+1:2];
      r_s1.wdata <= w_port ? req_wdata1 : req_wdata0;
      r_s1.err   <= w_err;
    end else begin
      r_s1.vld <= 1'b0;
      r_s1.we  <= 1'b0;
      r_s1.re  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= '0;
    end else begin
      r_s2.vld    <= r_s1.vld;
      r_s2.port   <= r_s1.port;
      r_s2.err    <= r_s1.err;
      r_s2.had_re <= r_s1.re;
    end
  end

  assign mem_addr  = r_s1.idx;
  assign mem_we    = r_s1.we;
  assign mem_re    = r_s1.re;
  assign mem_wdata = r_s1.wdata;

  // had_re is clear for error slots, which forces the zero read data they must return.
  assign rsp_valid = r_s2.vld ? (r_s2.port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err   = r_s2.vld & r_s2.err;
  assign rsp_rdata = r_s2.had_re ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter, transaction-queue reference model plus directed literals
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_we = '0, req_re = '0;
  logic [31:0] req_addr0 = '0, req_addr1 = '0, req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic        rsp_err, mem_we, mem_re;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [6:0]  mem_addr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_re(req_re),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: registered read, write-first when read and write hit together.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each accepted request becomes a transaction due on the response
  // sample two cycles later; its memory effect is applied one cycle after acceptance.
  typedef struct {
    int       due;
    bit       port;
    bit       we;
    bit       re;
    bit       err;
    bit [6:0] idx;
    bit [31:0] wdata;
    bit [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [128];
  bit          m_turn1 = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin : model
    exp_t        e;
    logic [1:0]  g;
    logic [31:0] a;
    bit          ok;
    cyc++;
    if (!rst_n) begin
      chk("rst_ctl", 64'({req_ready, rsp_valid, rsp_err, mem_we, mem_re}), 64'd0);
      chk("rst_data", 64'({rsp_rdata, mem_addr}), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      q.delete();
      m_turn1 = 1'b0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), e.port ? 64'd2 : 64'd1);
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        if (e.err) chk("rsp_rdata_err", 64'(rsp_rdata), 64'd0);
        else if (e.re) chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end else begin
        chk("rsp_idle", 64'({rsp_valid, rsp_err}), 64'd0);
      end
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        ok = !q[0].err;
        chk("mem_we", 64'(mem_we), 64'(q[0].we && ok));
        chk("mem_re", 64'(mem_re), 64'(q[0].re && ok));
        if (ok && (q[0].we || q[0].re)) chk("mem_addr", 64'(mem_addr), 64'(q[0].idx));
        if (ok && q[0].we) begin
          chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
          m_mem[q[0].idx] = q[0].wdata;
        end
        if (ok && q[0].re) q[0].rdata = m_mem[q[0].idx];
      end else begin
        chk("mem_idle", 64'({mem_we, mem_re}), 64'd0);
      end
`ifdef DMEM_ARB_RR_EN
      if (req_valid == 2'b11) begin
        g = m_turn1 ? 2'b10 : 2'b01;
        m_turn1 = !m_turn1;
      end else begin
        g = req_valid;
      end
`else
      g = (req_valid == 2'b11) ? 2'b01 : req_valid;
`endif
      chk("req_ready", 64'(req_ready), 64'(g));
      if (g != 2'b00) begin
        e.due   = cyc + 2;
        e.port  = g[1];
        a       = e.port ? req_addr1 : req_addr0;
        e.err   = (a % 4 != 0) || (a >= 512);
        e.idx   = 7'((a / 4) % 128);
        e.we    = req_we[e.port];
        e.re    = req_re[e.port];
        e.wdata = e.port ? req_wdata1 : req_wdata0;
        e.rdata = '0;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] re,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] w0, input logic [31:0] w1);
    @(posedge clk);
    #1;
    req_valid = v; req_we = we; req_re = re;
    req_addr0 = a0; req_addr1 = a1; req_wdata0 = w0; req_wdata1 = w1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 8) return 32'($urandom_range(0, 31)) << 2;
    else if (r == 8) return (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
    else return 32'($urandom) | 32'h200;
  endfunction

  logic [1:0] t2_exp [6];

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = '0;
      m_mem[i] = '0;
    end
`ifdef DMEM_ARB_RR_EN
    t2_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
`else
    t2_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
`endif
    req_valid = 2'b11;
    sample();
    chk("rst_ready_gated", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both ports read continuously, then port 0 drops out.
    for (int i = 0; i < 6; i++) begin
      drive(i < 4 ? 2'b11 : (i == 4 ? 2'b10 : 2'b00), 2'b00, 2'b11, 32'h40, 32'h44, '0, '0);
      sample();
      chk($sformatf("t2_ready%0d", i), 64'(req_ready), 64'(t2_exp[i]));
      if (i >= 2) chk($sformatf("t2_rsp%0d", i), 64'(rsp_valid), 64'(t2_exp[i-2]));
    end
    idle(2);

    // Write then read the same word from port 0.
    drive(2'b01, 2'b01, 2'b00, 32'h10, '0, 32'hDEADBEEF, '0);
    drive(2'b01, 2'b00, 2'b01, 32'h10, '0, '0, '0);
    sample();
    chk("t1_mem_we", 64'({mem_we, mem_re}), 64'd2);
    chk("t1_mem_addr", 64'(mem_addr), 64'd4);
    idle(2);
    sample();
    chk("t1_rsp", 64'({rsp_valid, rsp_err}), 64'd2);
    chk("t1_rdata", 64'(rsp_rdata), 64'hDEADBEEF);

    // Bad addresses on port 1.
    drive(2'b10, 2'b00, 2'b10, '0, 32'h3, '0, '0);
    drive(2'b10, 2'b00, 2'b10, '0, 32'h200, '0, '0);
    sample();
    chk("t4_mem_re0", 64'({mem_we, mem_re}), 64'd0);
    idle(1);
    sample();
    chk("t4_rsp0", 64'({rsp_valid, rsp_err, rsp_rdata}), {29'd0, 2'b10, 1'b1, 32'd0});
    chk("t4_mem_re1", 64'({mem_we, mem_re}), 64'd0);
    idle(1);
    sample();
    chk("t4_rsp1", 64'({rsp_valid, rsp_err, rsp_rdata}), {29'd0, 2'b10, 1'b1, 32'd0});

    // Combined write+read, then a plain read of the same word.
    drive(2'b01, 2'b01, 2'b01, 32'h7C, '0, 32'h1234, '0);
    idle(2);
    sample();
    chk("t5_wr_rdata", 64'(rsp_rdata), 64'h1234);
    drive(2'b01, 2'b00, 2'b01, 32'h7C, '0, '0, '0);
    idle(2);
    sample();
    chk("t5_rd_rdata", 64'(rsp_rdata), 64'h1234);

    // Reset lands while a write sits in the command stage.
    drive(2'b01, 2'b01, 2'b00, 32'h20, '0, 32'h11111111, '0);
    idle(2);
    drive(2'b01, 2'b01, 2'b00, 32'h20, '0, 32'hCAFEF00D, '0);
    @(posedge clk);
    #1;
    chk("t6_we_live", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_re = 2'b00;
    #1 chk("t6_we_cut", 64'(mem_we), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(2'b01, 2'b00, 2'b01, 32'h20, '0, '0, '0);
    idle(2);
    sample();
    chk("t6_rsp", 64'({rsp_valid, rsp_err}), 64'd2);
    chk("t6_rdata", 64'(rsp_rdata), 64'h11111111);

    for (int i = 0; i < 600; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            rand_addr(), rand_addr(), $urandom, $urandom);
    end
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
